// File: rtl/vga_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths, arbiter
// state encoding and the readout phases reserved for display fetches.
package vga_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arbState_t;

  // Readout phases (dispCount[1:0]) in which the display drives VRAM
  localparam logic [1:0] DISP_SLOT_A = 2'b00;
  localparam logic [1:0] DISP_SLOT_B = 2'b01;

  function automatic logic isDispSlot(input logic [1:0] phase);
    return (phase == DISP_SLOT_A) || (phase == DISP_SLOT_B);
  endfunction

endpackage

// File: rtl/vram_slot_predict.sv
// Predicts whether the next cycle is free for a host VRAM access.
// Build option VRAM_ARB_BLANK_ONLY_EN restricts host access to vertical
// blanking (tear-free updates); otherwise host accesses interleave with
// display fetches inside the 8-cycle readout phase.
module vram_slot_predict
  import vga_pkg::*;
(
  input  logic       dispActive,
  input  logic [2:0] dispCount,
  input  logic       vActive,
  output logic       grantOk
);

`ifdef VRAM_ARB_BLANK_ONLY_EN
  logic w_unused;

  assign w_unused = ^{1'b0, dispActive, dispCount};

  // Host only gets the bus while the display is in vertical blanking
  assign grantOk = ~vActive;
`else
  logic [1:0] w_nextPhase;
  logic       w_unused;

  assign w_unused = ^{1'b0, vActive, dispCount[2]};

  // The slot after this one is free unless it is a display-reserved phase.
  // Readout always starts activity at phase 2, so an idle display never
  // turns a predicted-free slot into an owned one.
  assign w_nextPhase = dispCount[1:0] + 2'd1;
  assign grantOk     = ~dispActive | ~isDispSlot(w_nextPhase);
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the display readout path and the host
// access port. Display fetches own fixed slots; host reads/writes are
// placed only into slots predicted free by vram_slot_predict.
// Optional build macro: VRAM_ARB_BLANK_ONLY_EN (host access only during
// vertical blanking).
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vActive,
  input  logic              dispActive,
  input  logic [2:0]        dispCount,
  input  logic [ADDR_W-1:0] readoutAddr,
  input  logic              hostReq,
  input  logic              hostWe,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWData,
  output logic              hostAck,
  output logic [DATA_W-1:0] hostRData,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramWData,
  output logic              vramWe,
  input  logic [DATA_W-1:0] vramRData
);

  arbState_t         r_state;
  arbState_t         w_nextState;
  logic              w_grantOk;
  logic              w_accept;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata;

  vram_slot_predict u_slotPredict (
    .dispActive (dispActive),
    .dispCount  (dispCount),
    .vActive    (vActive),
    .grantOk    (w_grantOk)
  );

  // State register; reset aborts any access in flight without an ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and VRAM pin muxing; the host only drives VRAM in ACCESS
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    hostAck     = 1'b0;
    vramAddr    = readoutAddr;
    vramWe      = 1'b0;
    case (r_state)
      IDLE: begin
        if (hostReq && w_grantOk) begin
          w_accept    = 1'b1;
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        vramAddr    = r_addr;
        vramWe      = r_we;
        w_nextState = ACK;
      end
      ACK: begin
        hostAck     = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Capture the host request only on the edge that enters ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= hostAddr;
      r_wdata <= hostWData;
      r_we    <= hostWe;
    end
  end

  // Read data is taken from the asynchronous SRAM at the end of ACCESS
  // and held until the next read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if ((r_state == ACCESS) && !r_we) begin
      r_rdata <= vramRData;
    end
  end

  assign vramWData = r_wdata;
  assign hostRData = r_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter. A small VRAM model
// (asynchronous read, write on the clock edge) sits on the VRAM pins.
// Optional build macro: VRAM_ARB_BLANK_ONLY_EN.
module tb_vram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              vActive;
  logic              dispActive;
  logic [2:0]        dispCount;
  logic [ADDR_W-1:0] readoutAddr;
  logic              hostReq;
  logic              hostWe;
  logic [ADDR_W-1:0] hostAddr;
  logic [DATA_W-1:0] hostWData;
  logic              hostAck;
  logic [DATA_W-1:0] hostRData;
  logic [ADDR_W-1:0] vramAddr;
  logic [DATA_W-1:0] vramWData;
  logic              vramWe;
  logic [DATA_W-1:0] vramRData;

  logic [DATA_W-1:0] mem [0:8191];
  int                checks   = 0;
  int                failures = 0;
  bit                dispRun  = 1'b0;

  vram_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vActive     (vActive),
    .dispActive  (dispActive),
    .dispCount   (dispCount),
    .readoutAddr (readoutAddr),
    .hostReq     (hostReq),
    .hostWe      (hostWe),
    .hostAddr    (hostAddr),
    .hostWData   (hostWData),
    .hostAck     (hostAck),
    .hostRData   (hostRData),
    .vramAddr    (vramAddr),
    .vramWData   (vramWData),
    .vramWe      (vramWe),
    .vramRData   (vramRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: asynchronous read, write at the clock edge
  assign vramRData = mem[vramAddr];
  always @(posedge clk) begin
    if (vramWe) mem[vramAddr] <= vramWData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge and step the readout model
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (dispRun) begin
      dispCount   = dispCount + 3'd1;
      readoutAddr = readoutAddr + 13'd1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackCount;
    int weCount;
    int dblAck;
    int latency;
    logic prevAck;

    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    mem[13'h1FFF] = 8'hA5;
    rst         = 1'b1;
    vActive     = 1'b0;
    dispActive  = 1'b0;
    dispCount   = 3'd0;
    readoutAddr = 13'h0A00;
    hostReq     = 1'b0;
    hostWe      = 1'b0;
    hostAddr    = '0;
    hostWData   = '0;

    // Reset state
    @(negedge clk);
    checkOutput("rst hostAck", 32'(hostAck), 32'h0);
    checkOutput("rst vramWe", 32'(vramWe), 32'h0);
    checkOutput("rst hostRData", 32'(hostRData), 32'h0);
    checkOutput("rst vramWData", 32'(vramWData), 32'h0);
    checkOutput("rst vramAddr", 32'(vramAddr), 32'h0A00);
    #1 rst = 1'b0;

    // Write 0x41 to 0x0123 with the display idle
    applyStimulus();
    hostReq = 1'b1; hostWe = 1'b1; hostAddr = 13'h0123; hostWData = 8'h41;
    @(negedge clk);
    checkOutput("t1 req vramWe", 32'(vramWe), 32'h0);
    checkOutput("t1 req hostAck", 32'(hostAck), 32'h0);
    applyStimulus();
    hostAddr = 13'h0999; hostWData = 8'hEE;
    @(negedge clk);
    checkOutput("t1 acc vramWe", 32'(vramWe), 32'h1);
    checkOutput("t1 acc vramAddr", 32'(vramAddr), 32'h0123);
    checkOutput("t1 acc vramWData", 32'(vramWData), 32'h41);
    checkOutput("t1 acc hostAck", 32'(hostAck), 32'h0);
    applyStimulus();
    hostReq = 1'b0;
    @(negedge clk);
    checkOutput("t1 ack hostAck", 32'(hostAck), 32'h1);
    checkOutput("t1 ack vramWe", 32'(vramWe), 32'h0);
    checkOutput("t1 ack vramAddr", 32'(vramAddr), 32'h0A00);
    checkOutput("t1 ack vramWData", 32'(vramWData), 32'h41);
    applyStimulus();
    @(negedge clk);
    checkOutput("t1 post hostAck", 32'(hostAck), 32'h0);
    checkOutput("t1 mem", 32'(mem[13'h0123]), 32'h41);

    // Read 0x1FFF, model returns 0xA5
    applyStimulus();
    hostReq = 1'b1; hostWe = 1'b0; hostAddr = 13'h1FFF;
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    checkOutput("t3 acc vramWe", 32'(vramWe), 32'h0);
    checkOutput("t3 acc vramAddr", 32'(vramAddr), 32'h1FFF);
    checkOutput("t3 acc hostRData", 32'(hostRData), 32'h0);
    applyStimulus();
    hostReq = 1'b0;
    @(negedge clk);
    checkOutput("t3 ack hostAck", 32'(hostAck), 32'h1);
    checkOutput("t3 ack hostRData", 32'(hostRData), 32'hA5);
    applyStimulus();
    @(negedge clk);
    checkOutput("t3 hold hostRData", 32'(hostRData), 32'hA5);
    checkOutput("t3 hold hostAck", 32'(hostAck), 32'h0);

`ifndef VRAM_ARB_BLANK_ONLY_EN
    // Active display, request arriving at count 3
    applyStimulus();
    dispActive = 1'b1; dispCount = 3'd3; readoutAddr = 13'h0100; dispRun = 1'b1;
    hostReq = 1'b1; hostWe = 1'b1; hostAddr = 13'h0456; hostWData = 8'h5A;
    @(negedge clk);
    checkOutput("t2 c3 vramWe", 32'(vramWe), 32'h0);
    checkOutput("t2 c3 vramAddr", 32'(vramAddr), 32'h0100);
    applyStimulus();
    @(negedge clk);
    checkOutput("t2 c4 vramWe", 32'(vramWe), 32'h0);
    checkOutput("t2 c4 vramAddr", 32'(vramAddr), 32'h0101);
    applyStimulus();
    @(negedge clk);
    checkOutput("t2 c5 vramWe", 32'(vramWe), 32'h0);
    checkOutput("t2 c5 vramAddr", 32'(vramAddr), 32'h0102);
    applyStimulus();
    @(negedge clk);
    checkOutput("t2 c6 vramWe", 32'(vramWe), 32'h1);
    checkOutput("t2 c6 vramAddr", 32'(vramAddr), 32'h0456);
    checkOutput("t2 c6 vramWData", 32'(vramWData), 32'h5A);
    applyStimulus();
    hostReq = 1'b0;
    @(negedge clk);
    checkOutput("t2 c7 hostAck", 32'(hostAck), 32'h1);
    applyStimulus();
    @(negedge clk);
    checkOutput("t2 c0 vramAddr", 32'(vramAddr), 32'h0105);
    checkOutput("t2 c0 hostAck", 32'(hostAck), 32'h0);
    applyStimulus();
    @(negedge clk);
    checkOutput("t2 c1 vramAddr", 32'(vramAddr), 32'h0106);
    checkOutput("t2 c1 vramWe", 32'(vramWe), 32'h0);
    dispRun = 1'b0; dispActive = 1'b0;

    // Back-to-back writes across a 64-cycle scanline starting at count 2
    applyStimulus();
    dispActive = 1'b1; dispCount = 3'd2; readoutAddr = 13'h0200; dispRun = 1'b1;
    hostReq = 1'b1; hostWe = 1'b1;
    ackCount = 0; weCount = 0; dblAck = 0; prevAck = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i != 0) applyStimulus();
      hostAddr  = 13'h0300 + 13'(i);
      hostWData = 8'(i);
      @(negedge clk);
      if (dispCount[1:0] == 2'b00 || dispCount[1:0] == 2'b01) begin
        checkOutput("t4 slot vramAddr", 32'(vramAddr), 32'(readoutAddr));
        checkOutput("t4 slot vramWe", 32'(vramWe), 32'h0);
      end
      if (hostAck) begin
        ackCount++;
        if (prevAck) dblAck++;
      end
      prevAck = hostAck;
      if (vramWe) weCount++;
    end
    checkOutput("t4 ack count", 32'(ackCount), 32'd16);
    checkOutput("t4 write count", 32'(weCount), 32'd16);
    checkOutput("t4 double acks", 32'(dblAck), 32'd0);
    applyStimulus();
    hostReq = 1'b0; dispRun = 1'b0; dispActive = 1'b0;
    applyStimulus();
    applyStimulus();
    @(negedge clk);
    checkOutput("t4 hostRData held", 32'(hostRData), 32'hA5);
    checkOutput("t4 idle hostAck", 32'(hostAck), 32'h0);
`endif

    // Asynchronous reset in the middle of ACCESS
    applyStimulus();
    hostReq = 1'b1; hostWe = 1'b1; hostAddr = 13'h0777; hostWData = 8'h33;
    @(negedge clk);
    applyStimulus();
    hostReq = 1'b0;
    @(negedge clk);
    checkOutput("t5 acc vramWe", 32'(vramWe), 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5 rst vramWe", 32'(vramWe), 32'h0);
    checkOutput("t5 rst vramAddr", 32'(vramAddr), 32'(readoutAddr));
    checkOutput("t5 rst hostRData", 32'(hostRData), 32'h0);
    #1 rst = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("t5 no hostAck", 32'(hostAck), 32'h0);
    checkOutput("t5 idle vramWe", 32'(vramWe), 32'h0);
    checkOutput("t5 mem untouched", 32'(mem[13'h0777]), 32'h0);
    applyStimulus();
    hostReq = 1'b1; hostWData = 8'h34;
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    checkOutput("t5 retry vramWe", 32'(vramWe), 32'h1);
    applyStimulus();
    hostReq = 1'b0;
    @(negedge clk);
    checkOutput("t5 retry hostAck", 32'(hostAck), 32'h1);
    checkOutput("t5 retry mem", 32'(mem[13'h0777]), 32'h34);

    // vActive high with a pending request
    applyStimulus();
    vActive = 1'b1; dispActive = 1'b0;
    hostReq = 1'b1; hostWe = 1'b1; hostAddr = 13'h0010; hostWData = 8'h77;
`ifdef VRAM_ARB_BLANK_ONLY_EN
    weCount = 0; ackCount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vramWe) weCount++;
      if (hostAck) ackCount++;
      applyStimulus();
    end
    checkOutput("t6 no access", 32'(weCount), 32'd0);
    checkOutput("t6 no ack", 32'(ackCount), 32'd0);
    vActive = 1'b0;
`endif
    // Count cycles from the first free request cycle to the ack
    latency = 0;
    @(negedge clk);
    for (int k = 1; k <= 4 && latency == 0; k++) begin
      applyStimulus();
      @(negedge clk);
      if (hostAck) latency = k;
    end
    checkOutput("t6 ack latency", 32'(latency), 32'd2);
    checkOutput("t6 mem", 32'(mem[13'h0010]), 32'h77);
    applyStimulus();
    hostReq = 1'b0; vActive = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("t6 idle hostAck", 32'(hostAck), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
